// File: rtl/bin_to_7seg_scan.sv
// Prescaled up/down counter -> sequential double-dabble BCD converter -> multiplexed 7-seg scanner.
// Define SEG7_LZB_EN to blank leading zero digits; undefined drives every digit.
module bin_to_7seg_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned PRESCALE = 3000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              UP,
  input  logic              PAUSE,
  output logic              OVF,
  output logic [9:0]        LEDout,
  output logic [6:0]        SEG7OUT,
  output logic [DIGITS-1:0] SEG7COM
);

  localparam int unsigned PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BW = 4 * DIGITS;

  localparam logic [PW-1:0]    PRE_LAST   = PW'(PRESCALE);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0]    SH_LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // ---------------- prescaler and counter ----------------
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (tick && !PAUSE) begin
      if (UP) begin
        cnt_d = cnt_q + WIDTH'(1);
        ovf_d = (cnt_q == CNT_MAX);
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        ovf_d = (cnt_q == '0);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;

  if (WIDTH >= 10) begin : g_led_trunc
    assign LEDout = cnt_q[9:0];
  end else begin : g_led_ext
    assign LEDout = {{(10 - WIDTH){1'b0}}, cnt_q};
  end

  // ---------------- binary to BCD converter ----------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] conv_q, conv_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CW-1:0]    shcnt_q, shcnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    disp_q, disp_d;
  logic [3:0]       adj;
  logic             carry;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    conv_d  = conv_q;
    last_d  = last_q;
    shcnt_d = shcnt_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    adj     = '0;
    carry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != last_q) begin
          sh_d    = cnt_q;
          conv_d  = cnt_q;
          bcd_d   = '0;
          shcnt_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust each nibble then shift left, rippling each nibble's MSB into the next.
        carry = sh_q[WIDTH-1];
        for (int i = 0; i < DIGITS; i++) begin
          adj              = dabble(bcd_q[i*4 +: 4]);
          bcd_d[i*4 +: 4]  = {adj[2:0], carry};
          carry            = adj[3];
        end
        sh_d    = sh_q << 1;
        shcnt_d = shcnt_q + CW'(1);
        if (shcnt_q == SH_LAST) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        last_d  = conv_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      conv_q  <= '0;
      last_q  <= '0;
      shcnt_q <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      conv_q  <= conv_d;
      last_q  <= last_d;
      shcnt_q <= shcnt_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
    end
  end

  // ---------------- digit scanner ----------------
  logic [DW-1:0] dwell_q, dwell_d;
  logic [IW-1:0] scan_q, scan_d;
  logic [3:0]    nib_sel;

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    scan_d  = scan_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      scan_d  = (scan_q == IDX_LAST) ? '0 : scan_q + IW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dwell_q <= '0;
      scan_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      scan_q  <= scan_d;
    end
  end

  // COM and SEG both decode the same scan index, so they switch together.
  always_comb begin
    nib_sel = '0;
    SEG7COM = '0;
    for (int i = 0; i < DIGITS; i++) begin
      SEG7COM[i] = (scan_q == IW'(i));
      if (scan_q == IW'(i)) nib_sel = disp_q[i*4 +: 4];
    end
  end

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  logic              blank_sel;

  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    blank_sel  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp_q[i*4 +: 4] != 4'd0) upper_zero = 1'b0;
      blank[i] = upper_zero && (i != 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == IW'(i)) blank_sel = blank[i];
    end
    SEG7OUT = blank_sel ? 7'b1111111 : seg7(nib_sel);
  end
`else
  always_comb begin
    SEG7OUT = seg7(nib_sel);
  end
`endif

endmodule

// File: tb/tb_bin_to_7seg_scan.sv
// Directed bench for bin_to_7seg_scan with WIDTH=8, DIGITS=3, PRESCALE=3, SCAN_DIV=2.
module tb_bin_to_7seg_scan;

  logic       CLK;
  logic       RSTn;
  logic       UP;
  logic       PAUSE;
  logic       OVF;
  logic [9:0] LEDout;
  logic [6:0] SEG7OUT;
  logic [2:0] SEG7COM;

  int vecs = 0;
  int errs = 0;
  int n    = 0;  // posedges since the last reset release

  bin_to_7seg_scan #(
    .WIDTH   (8),
    .DIGITS  (3),
    .PRESCALE(3),
    .SCAN_DIV(2)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .UP     (UP),
    .PAUSE  (PAUSE),
    .OVF    (OVF),
    .LEDout (LEDout),
    .SEG7OUT(SEG7OUT),
    .SEG7COM(SEG7COM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    n++;
  endtask

  task automatic step_to(input int t);
    while (n < t) step();
  endtask

  task automatic do_reset(input logic up, input logic pause);
    @(negedge CLK);
    RSTn  = 1'b0;
    UP    = up;
    PAUSE = pause;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    n    = 0;
  endtask

  // Walks six dwell slots; after posedge n the scan index is (n/2)%3.
  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    int         idx;
    logic [2:0] exp_com;
    logic [6:0] exp_seg;
    for (int k = 0; k < 6; k++) begin
      step();
      idx     = (n / 2) % 3;
      exp_com = 3'b001 << idx;
      exp_seg = (idx == 0) ? s0 : (idx == 1) ? s1 : s2;
      vecs++;
      if (SEG7COM !== exp_com) begin
        errs++;
        $display("FAIL scan_com n=%0d got %b want %b", n, SEG7COM, exp_com);
      end
      vecs++;
      if (SEG7OUT !== exp_seg) begin
        errs++;
        $display("FAIL scan_seg n=%0d got %b want %b", n, SEG7OUT, exp_seg);
      end
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b1; UP = 1'b1; PAUSE = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    vecs++; if (LEDout !== 10'd0) begin errs++; $display("FAIL rst_led got %0d want 0", LEDout); end
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", OVF); end
    vecs++; if (SEG7COM !== 3'b001) begin errs++; $display("FAIL rst_com got %b want 001", SEG7COM); end
    vecs++; if (SEG7OUT !== 7'b1000000) begin errs++; $display("FAIL rst_seg got %b want 1000000", SEG7OUT); end
    vecs++; if (dut.disp_q !== 12'h000) begin errs++; $display("FAIL rst_disp got %h want 000", dut.disp_q); end
  endtask

  task automatic test_count_up();
    do_reset(1'b1, 1'b0);
    step_to(3);
    vecs++; if (LEDout !== 10'd0) begin errs++; $display("FAIL up_pre_tick got %0d want 0", LEDout); end
    step();
    vecs++; if (LEDout !== 10'd1) begin errs++; $display("FAIL up_first_tick got %0d want 1", LEDout); end
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL up_no_ovf got %b want 0", OVF); end
    step_to(13);
    vecs++; if (dut.disp_q !== 12'h000) begin errs++; $display("FAIL up_disp_early got %h want 000", dut.disp_q); end
    step();
    vecs++; if (dut.disp_q !== 12'h001) begin errs++; $display("FAIL up_disp_latency got %h want 001", dut.disp_q); end
  endtask

  task automatic test_down_wrap();
    do_reset(1'b0, 1'b0);
    step_to(3);
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL dn_ovf_early got %b want 0", OVF); end
    step();
    vecs++; if (LEDout !== 10'd255) begin errs++; $display("FAIL dn_wrap_led got %0d want 255", LEDout); end
    vecs++; if (OVF !== 1'b1) begin errs++; $display("FAIL dn_wrap_ovf got %b want 1", OVF); end
    PAUSE = 1'b1;
    step();
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL dn_ovf_pulse got %b want 0", OVF); end
    step_to(13);
    vecs++; if (dut.disp_q !== 12'h000) begin errs++; $display("FAIL dn_disp_early got %h want 000", dut.disp_q); end
    step();
    vecs++; if (dut.disp_q !== 12'h255) begin errs++; $display("FAIL dn_disp got %h want 255", dut.disp_q); end
    scan_check(7'b0010010, 7'b0010010, 7'b0100100);
  endtask

  // Continues from 255 held by PAUSE at n=20.
  task automatic test_up_wrap();
    UP = 1'b1; PAUSE = 1'b0;
    step_to(23);
    vecs++; if (LEDout !== 10'd255) begin errs++; $display("FAIL uw_hold got %0d want 255", LEDout); end
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL uw_ovf_early got %b want 0", OVF); end
    step();
    vecs++; if (LEDout !== 10'd0) begin errs++; $display("FAIL uw_wrap_led got %0d want 0", LEDout); end
    vecs++; if (OVF !== 1'b1) begin errs++; $display("FAIL uw_wrap_ovf got %b want 1", OVF); end
    PAUSE = 1'b1;
    step();
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL uw_ovf_pulse got %b want 0", OVF); end
    step_to(33);
    vecs++; if (dut.disp_q !== 12'h255) begin errs++; $display("FAIL uw_disp_early got %h want 255", dut.disp_q); end
    step();
    vecs++; if (dut.disp_q !== 12'h000) begin errs++; $display("FAIL uw_disp got %h want 000", dut.disp_q); end
    scan_check(7'b1000000, 7'b1000000, 7'b1000000);
  endtask

  task automatic test_pause();
    do_reset(1'b1, 1'b0);
    step_to(8);
    vecs++; if (LEDout !== 10'd2) begin errs++; $display("FAIL ps_start got %0d want 2", LEDout); end
    PAUSE = 1'b1;
    repeat (80) begin
      step();
      vecs++; if (LEDout !== 10'd2) begin errs++; $display("FAIL ps_hold n=%0d got %0d want 2", n, LEDout); end
      vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL ps_ovf n=%0d got %b want 0", n, OVF); end
    end
    vecs++; if (dut.disp_q !== 12'h002) begin errs++; $display("FAIL ps_disp got %h want 002", dut.disp_q); end
    PAUSE = 1'b0;
    step_to(91);
    vecs++; if (LEDout !== 10'd2) begin errs++; $display("FAIL ps_resume_early got %0d want 2", LEDout); end
    step();
    vecs++; if (LEDout !== 10'd3) begin errs++; $display("FAIL ps_resume got %0d want 3", LEDout); end
  endtask

  // 127 converts from n=533; 128 arrives at n=536 mid-shift and converts afterwards.
  task automatic test_mid_change();
    logic [11:0] exp_disp;
    do_reset(1'b1, 1'b0);
    step_to(504);
    vecs++; if (LEDout !== 10'd126) begin errs++; $display("FAIL mc_126 got %0d want 126", LEDout); end
    PAUSE = 1'b1;
    step_to(531);
    vecs++; if (dut.disp_q !== 12'h126) begin errs++; $display("FAIL mc_settle got %h want 126", dut.disp_q); end
    PAUSE = 1'b0;
    while (n < 552) begin
      step();
      if (n == 536) PAUSE = 1'b1;
      if (n == 532) begin
        vecs++; if (LEDout !== 10'd127) begin errs++; $display("FAIL mc_127 got %0d want 127", LEDout); end
      end
      if (n == 536) begin
        vecs++; if (LEDout !== 10'd128) begin errs++; $display("FAIL mc_128 got %0d want 128", LEDout); end
      end
      exp_disp = (n < 542) ? 12'h126 : (n < 552) ? 12'h127 : 12'h128;
      vecs++;
      if (dut.disp_q !== exp_disp) begin
        errs++;
        $display("FAIL mc_disp n=%0d got %h want %h", n, dut.disp_q, exp_disp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b0);
    step_to(9);
    vecs++; if (dut.state_q !== 2'd1) begin errs++; $display("FAIL rm_in_shift got %0d want 1", dut.state_q); end
    vecs++; if (SEG7COM !== 3'b010) begin errs++; $display("FAIL rm_pre_com got %b want 010", SEG7COM); end
    vecs++; if (LEDout !== 10'd2) begin errs++; $display("FAIL rm_pre_led got %0d want 2", LEDout); end
    #1 RSTn = 1'b0;
    #1;
    vecs++; if (LEDout !== 10'd0) begin errs++; $display("FAIL rm_led got %0d want 0", LEDout); end
    vecs++; if (OVF !== 1'b0) begin errs++; $display("FAIL rm_ovf got %b want 0", OVF); end
    vecs++; if (SEG7COM !== 3'b001) begin errs++; $display("FAIL rm_com got %b want 001", SEG7COM); end
    vecs++; if (SEG7OUT !== 7'b1000000) begin errs++; $display("FAIL rm_seg got %b want 1000000", SEG7OUT); end
    vecs++; if (dut.state_q !== 2'd0) begin errs++; $display("FAIL rm_state got %0d want 0", dut.state_q); end
  endtask

  task automatic test_digits();
    do_reset(1'b1, 1'b0);
    step_to(28);
    vecs++; if (LEDout !== 10'd7) begin errs++; $display("FAIL dg_led got %0d want 7", LEDout); end
    PAUSE = 1'b1;
    step_to(50);
    vecs++; if (dut.disp_q !== 12'h007) begin errs++; $display("FAIL dg_disp got %h want 007", dut.disp_q); end
`ifdef SEG7_LZB_EN
    scan_check(7'b1111000, 7'b1111111, 7'b1111111);
`else
    scan_check(7'b1111000, 7'b1000000, 7'b1000000);
`endif
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_wrap();
    test_up_wrap();
    test_pause();
    test_mid_change();
    test_reset_mid();
    test_digits();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
